mcycle_seq: RTL and testbench
=============================

Name: mcycle_seq

Overview:
Multi-cycle multiply/divide sequencer for the single-cycle ARM core. It is started by the condition-qualified M_Start from the condition logic, latches the operands, and iterates one shift-add or restoring-subtract step per cycle. It stalls the pipeline through Busy until the result is ready, then presents registered results for register writeback.

Parameters:
WIDTH, 32, operand/result width; iteration count = WIDTH.

Ports:
CLK  in  1  system clock, rising edge.
RESETn  in  1  asynchronous, active-low reset.
M_Start  in  1  start request, already qualified by CondEx.
MCycleOp  in  2  bit1: 0=MUL, 1=DIV; bit0: 1=signed.
Operand1  in  WIDTH  multiplicand / dividend.
Operand2  in  WIDTH  multiplier / divisor.
Busy  out  1  pipeline stall request.
Done  out  1  one-cycle pulse; results valid.
Result1  out  WIDTH  product low / quotient.
Result2  out  WIDTH  product high / remainder.

Behaviour:
- Clock and reset: one clock (CLK); RESETn is asynchronous and active-low.
- Reset values: state=IDLE, Busy=0, Done=0, Result1=0, Result2=0, counter=0.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE:
  - If M_Start=1: latch magnitudes of Operand1/Operand2 (two's-complement absolute value if signed, else raw), latch MCycleOp, record result signs, counter=0, go to COMPUTE.
  - Busy is combinationally 1 in this start cycle, so the pipeline stalls immediately.
- COMPUTE:
  - Busy=1; one iteration per cycle; counter increments.
  - After iteration WIDTH-1, go to DONE.
  - MUL uses a 2*WIDTH shift-add accumulator; DIV uses restoring division (WIDTH quotient bits, MSB first).
- DONE:
  - Busy=0, Done=1.
  - Result1/Result2 are registered on entry to DONE, with sign fix-up applied.
  - M_Start is ignored here, because the stalled instruction still asserts it this cycle.
  - Unconditional return to IDLE.
- Latency: Busy high for WIDTH+1 cycles (start + WIDTH compute). Done is asserted in cycle WIDTH+1 relative to the start cycle (cycle 0).
- Result hold: Result1/Result2 hold their value until the next DONE or reset.
- Back-to-back: M_Start in the cycle after DONE (IDLE) is accepted normally.
- Operand stability: operand/op changes while Busy=1 are ignored (latched copy used).
- Signed MUL: product negated if the operand signs differ; full 2*WIDTH result.
- Signed DIV: quotient negated if the signs differ; remainder takes the dividend's sign.
- Most-negative / -1 wraps: quotient = 0x8000_0000, remainder = 0.
- Divide by zero (either signedness): Result1 = all ones, Result2 = Operand1 as latched (raw, no sign fix-up). Full latency still applies.
- Reset mid-operation: immediate return to IDLE; Busy and Done drop asynchronously; results cleared.

Optional Feature:
MCYCLE_EARLY_TERM_EN:
- Defined: MUL exits COMPUTE after the first iteration following which the remaining unshifted multiplier bits are all zero. The minimum is 1 compute cycle, so multiplier 0 gives Busy for 2 cycles. The accumulator is aligned correctly on exit. DIV is unaffected.
- Undefined: fixed WIDTH-iteration latency for all ops.

Decomposition:
- mcycle_pkg:
  - MCycleOp field encodings (OP_MUL, OP_DIV, OP_SIGNED bit).
  - State enum (IDLE, COMPUTE, DONE).
  - Counter width = $clog2(WIDTH).
- Sub-module mcycle_step: combinational single-iteration datapath (add-shift for MUL, trial-subtract-shift for DIV). mcycle_seq owns the FSM, counter, operand/result registers and sign fix-up.

Test Plan:
- Unsigned MUL 0x3 × 0x7, M_Start held until Done -> Busy=1 for cycles 0..32, Done at cycle 33, Result1=0x15, Result2=0; no restart in DONE.
- Signed MUL 0xFFFF_FFFE × 0x3 -> Result1=0xFFFF_FFFA, Result2=0xFFFF_FFFF; unsigned same operands -> Result1=0xFFFF_FFFA, Result2=0x2.
- DIV unsigned 100/7 -> Result1=0xE, Result2=0x2; signed 0xFFFF_FF9C/7 -> Result1=0xFFFF_FFF2, Result2=0xFFFF_FFFE.
- DIV 0x1234/0 -> Result1=0xFFFF_FFFF, Result2=0x1234 after 33 cycles; signed 0x8000_0000/0xFFFF_FFFF -> Result1=0x8000_0000, Result2=0.
- Back-to-back: second MUL 5×5 with M_Start in the cycle after Done -> accepted, Result1=0x19 at cycle 33 of the second op; Operand changes mid-op -> no effect.
- RESETn low at cycle 10 of a DIV -> Busy=0 and results=0 immediately; next M_Start runs a full 33 cycles. With MCYCLE_EARLY_TERM_EN, 3×7 -> Busy=4 cycles, Result1=0x15.

Source files
------------

// File: rtl/mcycle_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mcycle_pkg;

    localparam int OP_DIV_BIT    = 1;
    localparam int OP_SIGNED_BIT = 0;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mcycle_step.sv
// One shift-add (MUL) or restoring trial-subtract (DIV) iteration.
// Latency: combinational, zero cycles.
// Backpressure: none; the sequencer decides when a step is committed.
module mcycle_step
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 op_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opb,
    output logic [2*WIDTH-1:0]   acc_nxt
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH-1:0] diff;

    // MUL: acc = {partial product, unconsumed multiplier}, shifted right.
    // DIV: acc = {partial remainder, dividend/quotient}, shifted left.
    always_comb begin
        hi    = acc[2*WIDTH-1:WIDTH];
        lo    = acc[WIDTH-1:0];
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        rem_s = {hi, lo[WIDTH-1]};
        // When the trial subtract succeeds the difference is below the divisor,
        // so the low WIDTH bits of the modular difference are exact.
        diff  = rem_s[WIDTH-1:0] - opb;
        if (op_div == OP_MUL) begin
            acc_nxt = {sum, lo[WIDTH-1:1]};
        end else if (rem_s >= {1'b0, opb}) begin
            acc_nxt = {diff, lo[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {rem_s[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mcycle_seq.sv
// Multi-cycle MUL/DIV sequencer; optional MCYCLE_EARLY_TERM_EN shortens MUL.
// Latency: Busy for WIDTH+1 cycles from start, Done pulse on the next cycle.
// Backpressure: Busy stalls the pipeline combinationally from the start cycle.
module mcycle_seq
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             M_Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opb;
    logic                 op_div;
    logic                 div0;
    logic                 q_neg;
    logic                 r_neg;
    logic [WIDTH-1:0]     op1_raw;
    logic                 done_q;

    logic                 sgn_in;
    logic                 start_div;
    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [2*WIDTH-1:0]   fin_acc;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     res1;
    logic [WIDTH-1:0]     res2;
    logic                 early_exit;
    logic                 last_iter;

    assign sgn_in    = MCycleOp[OP_SIGNED_BIT];
    assign start_div = (MCycleOp[OP_DIV_BIT] == OP_DIV);
    assign mag1      = (sgn_in && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
    assign mag2      = (sgn_in && Operand2[WIDTH-1]) ? -Operand2 : Operand2;

    mcycle_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .op_div  (op_div),
        .acc     (acc),
        .opb     (opb),
        .acc_nxt (acc_nxt)
    );

    always_comb begin
        fin_acc    = acc_nxt;
        early_exit = 1'b0;
`ifdef MCYCLE_EARLY_TERM_EN
        // Remaining multiplier bits all zero: the rest would be pure shifts,
        // so apply them in one go and leave now.
        if ((op_div == OP_MUL) &&
            ((acc_nxt[WIDTH-1:0] & ({WIDTH{1'b1}} >> (int'(cnt) + 1))) == '0)) begin
            early_exit = 1'b1;
            fin_acc    = acc_nxt >> (WIDTH - 1 - int'(cnt));
        end
`endif
        last_iter = (cnt == LAST) || early_exit;
        quo       = fin_acc[WIDTH-1:0];
        rem       = fin_acc[2*WIDTH-1:WIDTH];
        prod      = q_neg ? -fin_acc : fin_acc;
        if (div0) begin
            res1 = {WIDTH{1'b1}};
            res2 = op1_raw;
        end else if (op_div == OP_DIV) begin
            res1 = q_neg ? -quo : quo;
            res2 = r_neg ? -rem : rem;
        end else begin
            res1 = prod[WIDTH-1:0];
            res2 = prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            op_div  <= 1'b0;
            div0    <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            op1_raw <= '0;
            done_q  <= 1'b0;
            Result1 <= '0;
            Result2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (M_Start) begin
                        op_div  <= start_div;
                        opb     <= start_div ? mag2 : mag1;
                        acc     <= {{WIDTH{1'b0}}, (start_div ? mag1 : mag2)};
                        div0    <= start_div && (Operand2 == '0);
                        op1_raw <= Operand1;
                        q_neg   <= sgn_in && (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
                        r_neg   <= sgn_in && Operand1[WIDTH-1];
                        cnt     <= '0;
                        state   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        Result1 <= res1;
                        Result2 <= res2;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // The stalled instruction still drives M_Start here; ignore it.
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign Done = done_q;
    assign Busy = RESETn && (((state == IDLE) && M_Start) || (state == COMPUTE));

endmodule

// File: tb/tb_mcycle_seq.sv
// Directed bench for mcycle_seq: MUL/DIV, signs, divide-by-zero, overflow,
// back-to-back starts, operand stability and mid-operation reset.
module tb_mcycle_seq;

    logic        CLK;
    logic        RESETn;
    logic        M_Start;
    logic [1:0]  MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic        Busy;
    logic        Done;
    logic [31:0] Result1;
    logic [31:0] Result2;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] MULU = 2'b00;
    localparam logic [1:0] MULS = 2'b01;
    localparam logic [1:0] DIVU = 2'b10;
    localparam logic [1:0] DIVS = 2'b11;

    mcycle_seq #(.WIDTH(32)) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .M_Start  (M_Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Busy     (Busy),
        .Done     (Done),
        .Result1  (Result1),
        .Result2  (Result2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected Busy length for a MUL: fixed WIDTH+1, or 1 + significant
    // multiplier bits (minimum one compute cycle) with early termination.
    function automatic int mul_cycles(input logic sgn, input logic [31:0] b);
        logic [31:0] m;
        int len;
        m   = (sgn && b[31]) ? -b : b;
        len = 0;
        for (int i = 0; i < 32; i++) if (m[i]) len = i + 1;
`ifdef MCYCLE_EARLY_TERM_EN
        return 1 + ((len < 1) ? 1 : len);
`else
        return (len >= 0) ? 33 : 33;
`endif
    endfunction

    // Starts an op in the current cycle, counts Busy cycles and checks the
    // Done cycle. Leaves M_Start asserted, as a stalled instruction would.
    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_cyc, input logic [31:0] e1,
                       input logic [31:0] e2, input bit scramble);
        int n;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        M_Start  = 1'b1;
        #1;
        chk({tag, "_busy0"}, 64'(Busy), 64'(1));
        n = 0;
        while (Busy === 1'b1 && n < 200) begin
            n++;
            tick();
            if (scramble && n == 1) begin
                Operand1 = $urandom;
                Operand2 = $urandom;
                MCycleOp = ~op;
            end
        end
        chk({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
        chk({tag, "_done"},   64'(Done), 64'(1));
        chk({tag, "_busy_done"}, 64'(Busy), 64'(0));
        chk({tag, "_r1"},     64'(Result1), 64'(e1));
        chk({tag, "_r2"},     64'(Result2), 64'(e2));
    endtask

    task automatic idle_after(input string tag, input logic [31:0] e1);
        M_Start = 1'b0;
        tick();
        chk({tag, "_done_drop"}, 64'(Done), 64'(0));
        chk({tag, "_idle_busy"}, 64'(Busy), 64'(0));
        chk({tag, "_hold_r1"},   64'(Result1), 64'(e1));
    endtask

    initial begin
        RESETn   = 1'b0;
        M_Start  = 1'b0;
        MCycleOp = 2'b00;
        Operand1 = '0;
        Operand2 = '0;
        tick();
        tick();
        chk("rst_busy", 64'(Busy), 64'(0));
        chk("rst_done", 64'(Done), 64'(0));
        chk("rst_r1",   64'(Result1), 64'(0));
        chk("rst_r2",   64'(Result2), 64'(0));
        RESETn = 1'b1;
        tick();

        // M_Start stays high through the DONE cycle: no restart there.
        run("mulu_3x7", MULU, 32'h3, 32'h7, mul_cycles(1'b0, 32'h7), 32'h15, 32'h0, 1'b0);
        idle_after("mulu_3x7", 32'h15);

        run("muls_m2x3", MULS, 32'hFFFF_FFFE, 32'h3, mul_cycles(1'b1, 32'h3),
            32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0);
        idle_after("muls_m2x3", 32'hFFFF_FFFA);

        run("mulu_fe3", MULU, 32'hFFFF_FFFE, 32'h3, mul_cycles(1'b0, 32'h3),
            32'hFFFF_FFFA, 32'h2, 1'b0);
        // Back-to-back: new operands while still in DONE, start in the next cycle.
        Operand1 = 32'h5;
        Operand2 = 32'h5;
        tick();
        run("b2b_5x5", MULU, 32'h5, 32'h5, mul_cycles(1'b0, 32'h5), 32'h19, 32'h0, 1'b1);
        idle_after("b2b_5x5", 32'h19);

        run("divu_100_7", DIVU, 32'd100, 32'd7, 33, 32'hE, 32'h2, 1'b0);
        idle_after("divu_100_7", 32'hE);

        run("divs_m100_7", DIVS, 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b1);
        idle_after("divs_m100_7", 32'hFFFF_FFF2);

        run("divu_by0", DIVU, 32'h1234, 32'h0, 33, 32'hFFFF_FFFF, 32'h1234, 1'b0);
        idle_after("divu_by0", 32'hFFFF_FFFF);

        run("divs_by0", DIVS, 32'hFFFF_FFF0, 32'h0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b0);
        idle_after("divs_by0", 32'hFFFF_FFFF);

        run("divs_ovf", DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0, 1'b0);
        idle_after("divs_ovf", 32'h8000_0000);

        // Reset ten cycles into a divide, with M_Start still asserted.
        MCycleOp = DIVU;
        Operand1 = 32'd1000;
        Operand2 = 32'd3;
        M_Start  = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        RESETn = 1'b0;
        #1;
        chk("midrst_busy", 64'(Busy), 64'(0));
        chk("midrst_done", 64'(Done), 64'(0));
        chk("midrst_r1",   64'(Result1), 64'(0));
        chk("midrst_r2",   64'(Result2), 64'(0));
        #1;
        RESETn = 1'b1;
        run("post_rst_div", DIVU, 32'd100, 32'd7, 33, 32'hE, 32'h2, 1'b0);
        idle_after("post_rst_div", 32'hE);

        run("mulu_9x0", MULU, 32'h9, 32'h0, mul_cycles(1'b0, 32'h0), 32'h0, 32'h0, 1'b0);
        idle_after("mulu_9x0", 32'h0);

        run("mulu_3x7_again", MULU, 32'h3, 32'h7, mul_cycles(1'b0, 32'h7), 32'h15, 32'h0, 1'b0);
        idle_after("mulu_3x7_again", 32'h15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
